// File: rtl/piano_pkg.sv
// piano_pkg
// Shared definitions for the piano note buffer record/playback path:
//   NOTE_W / DUR_W   widths of the note code and the tick-count field
//   DMAX             largest duration one event can hold
//   note_event_t     packed {note, dur} event as stored in the event RAM
//   pb_state_t       sequencer states
//   make_event()     builds an event from its two fields
package piano_pkg;

  localparam int NOTE_W = 6;
  localparam int DUR_W  = 8;

  localparam logic [DUR_W-1:0] DMAX     = {DUR_W{1'b1}};
  localparam logic [DUR_W-1:0] DUR_ZERO = {DUR_W{1'b0}};
  localparam logic [DUR_W-1:0] DUR_ONE  = {{(DUR_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } note_event_t;

  typedef enum logic [1:0] {
    REC      = 2'd0,
    PB_FETCH = 2'd1,
    PB_LOAD  = 2'd2,
    PB_HOLD  = 2'd3
  } pb_state_t;

  function automatic note_event_t make_event(input logic [NOTE_W-1:0] note,
                                             input logic [DUR_W-1:0]  dur);
    note_event_t ev;
    ev.note = note;
    ev.dur  = dur;
    return ev;
  endfunction

endpackage

// File: rtl/pb_event_packer.sv
// pb_event_packer
// Tracks the note currently being recorded and how many ticks it has been
// held, and raises a write request whenever a finished event must be stored.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           recording active: ticks and flushes are processed
//   tick         timebase strobe
//   note_in      live note code
//   flush        accepted playback request: push out the pending event
//   restart      (re)enter recording: adopt the live note, duration 0
//   wr_req       combinational request to store wr_event
//   wr_event     event to store
//   pending      a note with non-zero duration is being accumulated
module pb_event_packer
  import piano_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              tick,
  input  logic [NOTE_W-1:0] note_in,
  input  logic              flush,
  input  logic              restart,
  output logic              wr_req,
  output note_event_t       wr_event,
  output logic              pending
);

  logic [NOTE_W-1:0] cur_note_r;
  logic [NOTE_W-1:0] cur_note_s;
  logic [DUR_W-1:0]  dur_r;
  logic [DUR_W-1:0]  dur_s;
  logic              tick_wr_s;

  // Apply the tick first, then the flush, so a coincident tick and flush
  // produce at most one write.
  always_comb begin
    cur_note_s = cur_note_r;
    dur_s      = dur_r;
    tick_wr_s  = 1'b0;
    if (en && tick) begin
      if (note_in == cur_note_r) begin
        if (dur_r == DMAX) begin
          // Saturated: store a full-length event and keep counting the same note.
          tick_wr_s = 1'b1;
          dur_s     = DUR_ONE;
        end else begin
          dur_s     = dur_r + DUR_ONE;
        end
      end else begin
        tick_wr_s  = (dur_r != DUR_ZERO);
        cur_note_s = note_in;
        dur_s      = DUR_ONE;
      end
    end else begin
      cur_note_s = cur_note_r;
      dur_s      = dur_r;
    end

    if (en && flush && !tick_wr_s && (dur_s != DUR_ZERO)) begin
      wr_req   = 1'b1;
      wr_event = make_event(cur_note_s, dur_s);
    end else begin
      // Tick-driven writes always carry the note/duration held before the tick.
      wr_req   = tick_wr_s;
      wr_event = make_event(cur_note_r, dur_r);
    end
  end

  // Current note and held-tick count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_note_r <= {NOTE_W{1'b0}};
      dur_r      <= DUR_ZERO;
    end else if (restart) begin
      cur_note_r <= note_in;
      dur_r      <= DUR_ZERO;
    end else begin
      cur_note_r <= cur_note_s;
      dur_r      <= dur_s;
    end
  end

  assign pending = (dur_r != DUR_ZERO);

endmodule

// File: rtl/pb_sequencer.sv
// pb_sequencer
// Record/playback controller for the piano note buffer. Recording passes
// the live note through and stores {note, dur} events into the event RAM;
// playback reads them back in order and replays each for its tick count.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   tick                       timebase strobe (>= 4 clk apart)
//   note_in                    live note code
//   toggle_pb, clear           1-cycle control pulses
//   buf_wr_en/addr/data        event RAM write port
//   buf_rd_addr, buf_rd_data   event RAM read port (1-cycle read latency)
//   note_out                   note code to the tone generator
//   pb_mode                    high in any playback state
//   rec_count, full            stored event count and full flag
module pb_sequencer
  import piano_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tick,
  input  logic [NOTE_W-1:0]        note_in,
  input  logic                     toggle_pb,
  input  logic                     clear,
  output logic                     buf_wr_en,
  output logic [ADDR_W-1:0]        buf_wr_addr,
  output logic [NOTE_W+DUR_W-1:0]  buf_wr_data,
  output logic [ADDR_W-1:0]        buf_rd_addr,
  input  logic [NOTE_W+DUR_W-1:0]  buf_rd_data,
  output logic [NOTE_W-1:0]        note_out,
  output logic                     pb_mode,
  output logic [ADDR_W:0]          rec_count,
  output logic                     full
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  pb_state_t         state_r, state_s;
  logic [ADDR_W-1:0] rd_ptr_r, rd_ptr_s;
  logic [DUR_W-1:0]  remain_r, remain_s;
  logic [ADDR_W:0]   rec_count_r, rec_count_s;
  logic [NOTE_W-1:0] note_out_r, note_out_s;
  logic              wr_en_r, wr_en_s;
  logic [ADDR_W-1:0] wr_addr_r, wr_addr_s;
  note_event_t       wr_data_r, wr_data_s;
  logic              pb_mode_r, full_r;

  logic              toggle_s, rec_toggle_ok_s, last_s, at_full_s, restart_s;
  logic              wr_req_s, pending_s;
  note_event_t       wr_event_s, rd_event_s;

  // clear dominates toggle_pb; an empty recording with nothing pending ignores toggle.
  assign toggle_s        = toggle_pb && !clear;
  assign rec_toggle_ok_s = toggle_s && ((rec_count_r != {(ADDR_W+1){1'b0}}) || pending_s);
  assign last_s          = (({1'b0, rd_ptr_r} + CNT_ONE) >= rec_count_r);
  assign at_full_s       = (rec_count_r == DEPTH_C);
  assign restart_s       = clear || ((state_r != REC) && (state_s == REC));
  assign rd_event_s      = note_event_t'(buf_rd_data);

  pb_event_packer u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (state_r == REC),
    .tick     (tick),
    .note_in  (note_in),
    .flush    ((state_r == REC) && rec_toggle_ok_s),
    .restart  (restart_s),
    .wr_req   (wr_req_s),
    .wr_event (wr_event_s),
    .pending  (pending_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= REC;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic; clear first, then toggle, then tick.
  always_comb begin
    state_s = state_r;
    if (clear) begin
      state_s = REC;
    end else begin
      case (state_r)
        REC:      state_s = rec_toggle_ok_s ? PB_FETCH : REC;
        PB_FETCH: state_s = toggle_s ? REC : PB_LOAD;
        PB_LOAD:  state_s = toggle_s ? REC : PB_HOLD;
        PB_HOLD: begin
          if (toggle_s) begin
            state_s = REC;
          end else if (tick && (remain_r <= DUR_ONE)) begin
            state_s = last_s ? REC : PB_FETCH;
          end else begin
            state_s = PB_HOLD;
          end
        end
        default:  state_s = REC;
      endcase
    end
  end

  // FSM outputs and datapath next values.
  always_comb begin
    note_out_s  = note_out_r;
    wr_en_s     = 1'b0;
    wr_addr_s   = wr_addr_r;
    wr_data_s   = wr_data_r;
    rec_count_s = rec_count_r;
    rd_ptr_s    = rd_ptr_r;
    remain_s    = remain_r;
    if (clear) begin
      rec_count_s = {(ADDR_W+1){1'b0}};
      rd_ptr_s    = {ADDR_W{1'b0}};
      note_out_s  = {NOTE_W{1'b0}};
    end else begin
      case (state_r)
        REC: begin
          note_out_s = note_in;
          // Writes past the last slot are dropped without touching the count.
          if (wr_req_s && !at_full_s) begin
            wr_en_s     = 1'b1;
            wr_addr_s   = rec_count_r[ADDR_W-1:0];
            wr_data_s   = wr_event_s;
            rec_count_s = rec_count_r + CNT_ONE;
          end else begin
            wr_en_s     = 1'b0;
          end
          if (rec_toggle_ok_s) begin
            rd_ptr_s = {ADDR_W{1'b0}};
          end else begin
            rd_ptr_s = rd_ptr_r;
          end
        end
        PB_FETCH: begin
          if (toggle_s) begin
            note_out_s = {NOTE_W{1'b0}};
          end else begin
            note_out_s = note_out_r;
          end
        end
        PB_LOAD: begin
          if (toggle_s) begin
            note_out_s = {NOTE_W{1'b0}};
          end else begin
            note_out_s = rd_event_s.note;
            remain_s   = rd_event_s.dur;
          end
        end
        PB_HOLD: begin
          if (toggle_s) begin
            note_out_s = {NOTE_W{1'b0}};
          end else if (tick) begin
            if (remain_r > DUR_ONE) begin
              remain_s = remain_r - DUR_ONE;
            end else if (!last_s) begin
              rd_ptr_s = rd_ptr_r + PTR_ONE;
            end else begin
              note_out_s = {NOTE_W{1'b0}};
            end
          end else begin
            remain_s = remain_r;
          end
        end
        default: note_out_s = {NOTE_W{1'b0}};
      endcase
    end
  end

  // Registered outputs, pointers and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      note_out_r  <= {NOTE_W{1'b0}};
      wr_en_r     <= 1'b0;
      wr_addr_r   <= {ADDR_W{1'b0}};
      wr_data_r   <= make_event({NOTE_W{1'b0}}, DUR_ZERO);
      rec_count_r <= {(ADDR_W+1){1'b0}};
      rd_ptr_r    <= {ADDR_W{1'b0}};
      remain_r    <= DUR_ZERO;
      pb_mode_r   <= 1'b0;
      full_r      <= 1'b0;
    end else begin
      note_out_r  <= note_out_s;
      wr_en_r     <= wr_en_s;
      wr_addr_r   <= wr_addr_s;
      wr_data_r   <= wr_data_s;
      rec_count_r <= rec_count_s;
      rd_ptr_r    <= rd_ptr_s;
      remain_r    <= remain_s;
      pb_mode_r   <= (state_s != REC);
      full_r      <= (rec_count_s == DEPTH_C);
    end
  end

  assign buf_wr_en   = wr_en_r;
  assign buf_wr_addr = wr_addr_r;
  assign buf_wr_data = wr_data_r;
  assign buf_rd_addr = rd_ptr_r;
  assign note_out    = note_out_r;
  assign pb_mode     = pb_mode_r;
  assign rec_count   = rec_count_r;
  assign full        = full_r;

endmodule

// File: tb/tb_pb_sequencer.sv
// tb_pb_sequencer
// Bench for pb_sequencer with a 4-slot event RAM. Expected RAM writes are
// queued when the stimulus that causes them is driven and compared when the
// DUT raises buf_wr_en; note/mode/count values are checked at fixed points.
module tb_pb_sequencer;
  import piano_pkg::*;

  localparam int AW = 2;
  localparam int DW = NOTE_W + DUR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              tick = 1'b0;
  logic              toggle_pb = 1'b0;
  logic              clear = 1'b0;
  logic [NOTE_W-1:0] note_in = '0;
  logic              buf_wr_en;
  logic [AW-1:0]     buf_wr_addr;
  logic [DW-1:0]     buf_wr_data;
  logic [AW-1:0]     buf_rd_addr;
  logic [DW-1:0]     buf_rd_data = '0;
  logic [NOTE_W-1:0] note_out;
  logic              pb_mode;
  logic [AW:0]       rec_count;
  logic              full;

  int n_cmp = 0;
  int n_mis = 0;

  logic [AW+DW-1:0]  wr_q[$];
  logic [AW+DW-1:0]  wr_exp;
  logic [DW-1:0]     mem[0:(1<<AW)-1];
  logic              strobe_q = 1'b0;

  pb_sequencer #(.ADDR_W(AW), .DEPTH(1<<AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .note_in     (note_in),
    .toggle_pb   (toggle_pb),
    .clear       (clear),
    .buf_wr_en   (buf_wr_en),
    .buf_wr_addr (buf_wr_addr),
    .buf_wr_data (buf_wr_data),
    .buf_rd_addr (buf_rd_addr),
    .buf_rd_data (buf_rd_data),
    .note_out    (note_out),
    .pb_mode     (pb_mode),
    .rec_count   (rec_count),
    .full        (full)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM with write-first bypass on an address collision.
  always @(posedge clk) begin
    if (buf_wr_en) mem[buf_wr_addr] <= buf_wr_data;
    buf_rd_data <= (buf_wr_en && (buf_wr_addr == buf_rd_addr)) ? buf_wr_data : mem[buf_rd_addr];
    strobe_q    <= tick | toggle_pb;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic exp_wr(input int addr, input int note, input int dur);
    wr_q.push_back({AW'(addr), NOTE_W'(note), DUR_W'(dur)});
  endtask

  // Scoreboard: every write must be expected, in order, one cycle after a strobe.
  always @(negedge clk) begin
    if (rst_n && buf_wr_en) begin
      if (wr_q.size() == 0) begin
        check_val("wr_unexpected", 32'(buf_wr_en), 32'(0));
      end else begin
        wr_exp = wr_q.pop_front();
        check_val("wr_addr", 32'(buf_wr_addr), 32'(wr_exp[AW+DW-1:DW]));
        check_val("wr_data", 32'(buf_wr_data), 32'(wr_exp[DW-1:0]));
        check_val("wr_timing", 32'(strobe_q), 32'(1));
      end
    end
  end

  task automatic pulse_tick();
    @(posedge clk); #1 tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic pulse_toggle();
    @(posedge clk); #1 toggle_pb = 1'b1;
    @(posedge clk); #1 toggle_pb = 1'b0;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
  endtask

  task automatic wait_hold();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_note_out", 32'(note_out), 32'(0));
    check_val("rst_pb_mode", 32'(pb_mode), 32'(0));
    check_val("rst_wr_en", 32'(buf_wr_en), 32'(0));
    check_val("rst_addrs", 32'({buf_wr_addr, buf_rd_addr}), 32'(0));
    check_val("rst_count", 32'(rec_count), 32'(0));
    check_val("rst_full", 32'(full), 32'(0));
    @(posedge clk); #1 rst_n = 1'b1;

    // Note 5 for three ticks, then 7: one {5,3} event at address 0.
    note_in = 6'd5;
    @(posedge clk); @(negedge clk);
    check_val("live_pass", 32'(note_out), 32'(5));
    for (int i = 0; i < 3; i++) pulse_tick();
    note_in = 6'd7;
    exp_wr(0, 5, 3);
    pulse_tick();
    check_val("count_1", 32'(rec_count), 32'(1));

    // Second tick of 7, toggle flushes {7,2}, then play both events back.
    pulse_tick();
    exp_wr(1, 7, 2);
    note_in = 6'd9;
    pulse_toggle();
    @(negedge clk);
    check_val("pb_mode_on", 32'(pb_mode), 32'(1));
    check_val("rd_addr_0", 32'(buf_rd_addr), 32'(0));
    check_val("count_2", 32'(rec_count), 32'(2));
    wait_hold();
    @(negedge clk);
    check_val("pb_ev1", 32'(note_out), 32'(5));
    pulse_tick(); pulse_tick();
    check_val("pb_ev1_held", 32'(note_out), 32'(5));
    pulse_tick();
    check_val("pb_ev2", 32'(note_out), 32'(7));
    check_val("pb_mode_mid", 32'(pb_mode), 32'(1));
    pulse_tick(); pulse_tick();
    check_val("pb_done_mode", 32'(pb_mode), 32'(0));
    check_val("pb_done_live", 32'(note_out), 32'(9));

    // Abort during event 2, then replay from address 0.
    pulse_toggle();
    wait_hold();
    pulse_tick(); pulse_tick(); pulse_tick();
    check_val("ab_ev2", 32'(note_out), 32'(7));
    pulse_toggle();
    @(negedge clk);
    check_val("ab_note_zero", 32'(note_out), 32'(0));
    check_val("ab_mode", 32'(pb_mode), 32'(0));
    @(negedge clk);
    check_val("ab_live", 32'(note_out), 32'(9));
    pulse_toggle();
    @(negedge clk);
    check_val("replay_addr", 32'(buf_rd_addr), 32'(0));
    check_val("replay_mode", 32'(pb_mode), 32'(1));
    wait_hold();
    @(negedge clk);
    check_val("replay_ev1", 32'(note_out), 32'(5));
    pulse_toggle();

    // clear together with toggle and a write-causing tick.
    pulse_tick();
    note_in = 6'd11;
    @(posedge clk); #1 begin clear = 1'b1; toggle_pb = 1'b1; tick = 1'b1; end
    @(posedge clk); #1 begin clear = 1'b0; toggle_pb = 1'b0; tick = 1'b0; end
    @(negedge clk);
    check_val("clr_count", 32'(rec_count), 32'(0));
    check_val("clr_mode", 32'(pb_mode), 32'(0));
    check_val("clr_note", 32'(note_out), 32'(0));
    check_val("clr_full", 32'(full), 32'(0));
    @(negedge clk);
    check_val("clr_live", 32'(note_out), 32'(11));
    pulse_toggle();
    wait_hold();
    @(negedge clk);
    check_val("tog_ignored", 32'(pb_mode), 32'(0));
    check_val("tog_ign_live", 32'(note_out), 32'(11));

    // Hold note 3 for 257 ticks: saturated event, then flush of the remainder.
    note_in = 6'd3;
    exp_wr(0, 3, 255);
    for (int i = 0; i < 257; i++) pulse_tick();
    check_val("sat_count", 32'(rec_count), 32'(1));
    exp_wr(1, 3, 2);
    pulse_toggle();
    @(negedge clk);
    check_val("sat_flush_count", 32'(rec_count), 32'(2));
    wait_hold();
    @(negedge clk);
    check_val("sat_pb_note", 32'(note_out), 32'(3));
    pulse_toggle();

    // Fill all four slots; later events and the flush are dropped.
    pulse_clear();
    for (int k = 0; k < 7; k++) begin
      note_in = NOTE_W'(21 + k);
      if (k >= 1 && k <= 4) exp_wr(k - 1, 20 + k, 1);
      pulse_tick();
    end
    check_val("full_flag", 32'(full), 32'(1));
    check_val("full_count", 32'(rec_count), 32'(4));
    pulse_toggle();
    wait_hold();
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check_val("full_pb_note", 32'(note_out), 32'(21 + j));
      pulse_tick();
    end
    check_val("full_pb_done", 32'(pb_mode), 32'(0));
    check_val("full_pb_live", 32'(note_out), 32'(27));
    check_val("wr_pending", 32'(wr_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/pb_sequencer.md
Name: pb_sequencer

Overview:
Record/playback controller for the piano note buffer. In record mode it passes the live note through and packs every tick-sampled note into {note, duration} events written to a dual-port event RAM. In playback mode it reads the events back in order and replays each note for its recorded number of ticks. It sits between the debounced input stage (note code, toggle, clear pulses) and the tone generator, and owns the RAM's address and enable sequencing.

Parameters:
DEPTH, 64, number of event slots in the RAM.
ADDR_W, 6, RAM address width; DEPTH = 2**ADDR_W.
NOTE_W, 6, note code width; code 0 means rest/silence.
DUR_W, 8, duration field width in ticks; max held count DMAX = 2**DUR_W-1.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous, active-low reset.
tick  in  1  1-cycle timebase strobe, e.g. 256 Hz; consecutive strobes at least 4 clk apart.
note_in  in  NOTE_W  live note code from the debounced switches.
toggle_pb  in  1  1-cycle pulse: enter or abort playback.
clear  in  1  1-cycle pulse: erase the recording.
buf_wr_en  out  1  RAM write strobe.
buf_wr_addr  out  ADDR_W  RAM write address.
buf_wr_data  out  NOTE_W+DUR_W  event, {note, dur}.
buf_rd_addr  out  ADDR_W  RAM read address; read data is valid 1 cycle later.
buf_rd_data  in  NOTE_W+DUR_W  RAM read data.
note_out  out  NOTE_W  note code to the tone generator.
pb_mode  out  1  high while in any playback state.
rec_count  out  ADDR_W+1  number of stored events, 0..DEPTH.
full  out  1  high when rec_count == DEPTH.

Behaviour:
- Reset values: state=REC, note_out=0, pb_mode=0, buf_wr_en=0, addresses=0, rec_count=0, full=0, cur_note=0, dur=0, rd_ptr=0.
- All outputs are registered.
- States: REC, PB_FETCH, PB_LOAD, PB_HOLD.
- REC:
  - note_out <= note_in every cycle (1-cycle latency).
  - On a tick with note_in==cur_note and dur<DMAX: dur++.
  - On a tick with note_in==cur_note and dur==DMAX: write {cur_note, DMAX}; dur <= 1.
  - On a tick with note_in!=cur_note: if dur>0, write {cur_note, dur}; then cur_note <= note_in, dur <= 1.
  - A write means buf_wr_en=1 for exactly the cycle after the tick, addr=rec_count; rec_count increments in that same cycle.
  - Rests (code 0) are recorded like notes. An event with dur==0 is never written.
- Full: when rec_count==DEPTH, writes are dropped silently (no wr_en, no count change). Duration accounting continues.
- toggle_pb in REC:
  - Ignored if rec_count==0 and dur==0.
  - Otherwise flush the pending event (rule above, if dur>0 and not full), set rd_ptr=0, and go to PB_FETCH. pb_mode=1 from the next cycle.
- PB_FETCH: buf_rd_addr=rd_ptr → PB_LOAD.
- PB_LOAD: note_out <= note field, remain <= dur field → PB_HOLD.
- Ticks arriving in PB_FETCH or PB_LOAD are ignored.
- PB_HOLD: on tick, if remain>1 then remain--. If remain==1:
  - If rd_ptr+1 < rec_count: rd_ptr++ → PB_FETCH.
  - Else the playback is done: return to REC.
- Returning to REC (done, abort, or clear): pb_mode=0; note_out resumes live passthrough next cycle; cur_note <= note_in, dur <= 0. Recording appends after the existing events.
- toggle_pb in any PB state aborts: note_out <= 0 → REC.
- clear in any state: rec_count=0, full=0, rd_ptr=0, dur=0, note_out=0, state=REC, no write.
- Simultaneous events:
  - clear beats toggle_pb.
  - clear beats a tick write.
  - toggle_pb beats tick in PB states.
  - In REC, tick and toggle on the same cycle: the tick is applied first, then the flush (at most one write).
- rst_n mid-operation: immediate return to reset values. RAM contents are unaffected but unreachable, since rec_count=0.

Decomposition:
- Package piano_pkg holds:
  - NOTE_W and DUR_W constants.
  - Packed typedef note_event_t {note, dur}.
  - State enum pb_state_t.
- One sub-module, pb_event_packer: cur_note/dur accumulation and write-request generation for the REC path. The top module holds the FSM, pointers and RAM interface.

Test Plan:
- Reset, note_in=5 for 3 ticks, then 7 for 1 tick → one write {5,3} at addr 0 the cycle after the 4th tick; rec_count=1.
- Continue with note 7 for 2 ticks total, then toggle → flush {7,2} at addr 1. Playback: note_out=5 for 3 ticks, then 7 for 2 ticks, then back to REC with pb_mode=0.
- Hold note 3 for 257 ticks (DUR_W=8) → writes {3,255} with dur restarting at 1; on toggle, flush {3,2}.
- DEPTH=4, produce 6 note changes → exactly 4 writes (addrs 0-3), full=1, rec_count=4; later changes produce no wr_en.
- During playback of event 2, pulse toggle → note_out=0 next cycle, state REC; a further toggle replays from addr 0.
- clear asserted with toggle and tick on the same cycle → rec_count=0, no write, stays REC; a following toggle (with dur==0) is ignored.
